// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among NREQ requesters,
// with a credit-gated response FIFO. Optional statistics counters under `MUL_ARB_STATS_EN.
module mul_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int IDW        = $clog2(NREQ),
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_w,
  output logic [WIDTH-1:0]        mul_x,
  output logic [WIDTH-1:0]        mul_w,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_data,
`ifdef MUL_ARB_STATS_EN
  output logic [NREQ*16-1:0]      grant_cnt,
  output logic [15:0]             stall_cnt,
`endif
  output logic                    busy
);

  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNTW:0] DEPTH_C = (CNTW+1)'(FIFO_DEPTH);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

`ifdef MUL_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  logic [IDW-1:0]             last;
  logic [IDW:0]               cand;
  logic [IDW-1:0]             gnt;
  logic                       found;
  logic                       can_issue;
  logic                       hs;
  logic [MUL_LAT-1:0]         tag_vld;
  logic [IDW-1:0]             tag_id [MUL_LAT];
  logic [CNTW-1:0]            inflight;
  logic signed [2*WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [IDW-1:0]             fifo_id [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CNTW-1:0]            fifo_cnt;
  logic                       push;
  logic                       pop;

  // Credit: every issued op owns a FIFO slot from issue until it is popped.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) inflight = inflight + CNTW'(tag_vld[k]);
  end

  assign can_issue = ({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C;

  // Arbitration stage: first valid requester after the last grant.
  always_comb begin
    found = 1'b0;
    gnt   = last;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        gnt   = cand[IDW-1:0];
      end
    end
  end

  assign hs = found && can_issue && !rst;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt] = 1'b1;
  end

  assign mul_x = hs ? req_x[gnt*WIDTH +: WIDTH] : '0;
  assign mul_w = hs ? req_w[gnt*WIDTH +: WIDTH] : '0;

  assign push      = tag_vld[MUL_LAT-1];
  assign rsp_valid = (fifo_cnt != '0) && !rst;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign busy      = !rst && ((inflight != '0) || (fifo_cnt != '0));

  // Control state: pointer, tag valids, FIFO occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= IDW'(NREQ - 1);
      tag_vld  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (hs) last <= gnt;
      tag_vld[0] <= hs;
      for (int k = 1; k < MUL_LAT; k++) tag_vld[k] <= tag_vld[k-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Tag delay line and FIFO storage: data only, qualified by the valids above.
  always_ff @(posedge clk) begin
    tag_id[0] <= gnt;
    for (int k = 1; k < MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
    if (push) begin
      fifo_data[wr_ptr] <= mul_p;
      fifo_id[wr_ptr]   <= tag_id[MUL_LAT-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_cnt == CNTW'(FIFO_DEPTH)));

`ifdef MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (hs) grant_cnt[gnt*16 +: 16] <= sat_inc(grant_cnt[gnt*16 +: 16]);
      if (|req_valid && !can_issue) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
